// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Op codes, FSM states, default datapath width.
package hilo_muldiv_ctrl_pkg;

  localparam int MDU_LENGTH = 32;

  typedef enum logic [2:0] {
    MDU_OP_NOP   = 3'd0,
    MDU_OP_MULT  = 3'd1,
    MDU_OP_MULTU = 3'd2,
    MDU_OP_DIV   = 3'd3,
    MDU_OP_DIVU  = 3'd4,
    MDU_OP_MTHI  = 3'd5,
    MDU_OP_MTLO  = 3'd6,
    MDU_OP_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic mdu_op_live(
    input mdu_op_e op
  );
    return (op != MDU_OP_NOP) &&
           (op != MDU_OP_RSVD);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_divider.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// start/kill/is_signed/dividend/divisor in; busy/valid/quotient/remainder out.
module mdu_divider
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MDU_LENGTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign abs_a = a_neg ? -dividend : dividend;
  assign abs_b = b_neg ? -divisor : divisor;

  // Shift next dividend bit into the partial remainder.
  assign trial = {rem, quo[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs};
  assign fits  = trial >= {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      valid   <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      valid   <= 1'b0;
      cnt     <= CNT_W'(WIDTH);
      rem     <= '0;
      quo     <= abs_a;
      dvs     <= abs_b;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
    end else if (kill) begin
      running <= 1'b0;
      valid   <= 1'b0;
    end else if (running) begin
      rem <= fits ? diff[WIDTH-1:0]
                  : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        running <= 1'b0;
        valid   <= 1'b1;
      end
    end
  end

  assign busy      = running;
  assign quotient  = q_neg ? -quo : quo;
  assign remainder = r_neg ? -rem : rem;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute.
// req_* handshake, flush, busy/done status, registered hi/lo.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH   = MDU_LENGTH,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  mdu_op_e          op;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             mul_sgn;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] pipe [MUL_LAT];

  logic             div_busy;
  logic             div_valid;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  assign op        = mdu_op_e'(req_op);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid & req_ready &
                     ~flush & mdu_op_live(op);
  assign is_mul    = (op == MDU_OP_MULT) ||
                     (op == MDU_OP_MULTU);
  assign is_div    = (op == MDU_OP_DIV) ||
                     (op == MDU_OP_DIVU);

  // Sign-extend to full width so one unsigned
  // multiply serves both MULT and MULTU.
  assign mul_sgn = (op == MDU_OP_MULT);
  assign ext_a = {{WIDTH{mul_sgn & src_a[WIDTH-1]}},
                  src_a};
  assign ext_b = {{WIDTH{mul_sgn & src_b[WIDTH-1]}},
                  src_b};
  assign prod  = ext_a * ext_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++)
        pipe[i] <= '0;
    end else begin
      if (accept && is_mul)
        pipe[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept & is_div),
    .kill      (flush),
    .is_signed (op == MDU_OP_DIV),
    .dividend  (src_a),
    .divisor   (src_b),
    .busy      (div_busy),
    .valid     (div_valid),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_mul: begin
                state <= ST_MUL;
                cnt   <= CW'(MUL_LAT - 1);
              end
              is_div: begin
                state <= ST_DIV;
                cnt   <= CW'(WIDTH - 1);
              end
              (op == MDU_OP_MTHI): hi <= src_a;
              default:             lo <= src_a;
            endcase
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            {hi, lo} <= pipe[MUL_LAT-1];
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (flush)
            state <= ST_IDLE;
          else if (cnt == '0)
            state <= ST_FIX;
          else
            cnt <= cnt - 1'b1;
        end
        default: begin
          // Sign-corrected result is ready once
          // the core has retired its last bit.
          if (!flush && div_valid && !div_busy) begin
            lo   <= div_q;
            hi   <= div_r;
            done <= 1'b1;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl.
// Directed plus random ops against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] model = '0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(
    .WIDTH   (W),
    .MUL_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  // {hi,lo} after an op, from plain arithmetic.
  function automatic logic [63:0] ref_exec(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] cur
  );
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: res = 64'(sa * sb);
      3'd2: res = 64'(ua * ub);
      3'd3: begin
        if (b == 0) begin
          res = {a, (sa >= 0) ? 32'hFFFF_FFFF : 32'd1};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 0)
          res = {a, 32'hFFFF_FFFF};
        else
          res = {a % b, a / b};
      end
      3'd5: res = {a, cur[31:0]};
      3'd6: res = {cur[63:32], a};
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag);
    int cyc;
    int lat;
    logic [63:0] exp;
    bit lng;
    exp = ref_exec(op, a, b, model);
    lng = (op >= 3'd1) && (op <= 3'd4);
    lat = (op <= 3'd2) ? LAT : W + 1;
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'd0;
    if (lng) begin
      cyc = 0;
      while (busy && cyc < 100) begin
        cyc++;
        @(negedge clk);
      end
      check({tag, "_lat"}, 64'(cyc), 64'(lat));
      check({tag, "_done"}, 64'(done), 64'd1);
      @(negedge clk);
      check({tag, "_done_off"}, 64'(done), 64'd0);
    end else begin
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
    end
    model = exp;
    check({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    int cyc;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    src_a     = '0;
    src_b     = '0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;

    run_op(3'd5, 32'h1234_5678, 32'd0, "mthi");
    run_op(3'd6, 32'hDEAD_BEEF, 32'd0, "mtlo");
    run_op(3'd0, 32'h1111_1111, 32'd0, "nop");
    run_op(3'd7, 32'h2222_2222, 32'd0, "rsvd");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, "mult");
    check("mult_val", {hi, lo},
          64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'd2, 32'hFFFF_FFFD, 32'd5, "multu");
    check("multu_val", {hi, lo},
          64'h0000_0004_FFFF_FFF1);
    run_op(3'd4, 32'd100, 32'd7, "divu");
    check("divu_val", {hi, lo}, {32'd2, 32'd14});
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_neg_val", {hi, lo},
          64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_val", {hi, lo},
          {32'd0, 32'h8000_0000});
    run_op(3'd4, 32'h55, 32'd0, "divu_z");
    check("divu_z_val", {hi, lo},
          {32'h55, 32'hFFFF_FFFF});
    run_op(3'd3, 32'hFFFF_FF00, 32'd0, "div_zn");
    run_op(3'd3, 32'h0000_0100, 32'd0, "div_zp");

    // Flush mid-divide: no commit, no done.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd4;
    src_a     = 32'd1000;
    src_b     = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("fl_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_done", 64'(done), 64'd0);
    check("fl_hilo", {hi, lo}, model);
    @(negedge clk);
    check("fl_done2", 64'(done), 64'd0);

    // Flush alongside a request in idle drops it.
    req_valid = 1'b1;
    req_op    = 3'd5;
    src_a     = 32'hCAFE_0000;
    flush     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    check("fl_drop", {hi, lo}, model);

    // MTLO held while a divide is busy.
    req_valid = 1'b1;
    req_op    = 3'd3;
    src_a     = 32'hFFFF_FF9C;
    src_b     = 32'd7;
    @(negedge clk);
    model = ref_exec(3'd3, 32'hFFFF_FF9C, 32'd7, model);
    req_op = 3'd6;
    src_a  = 32'hA5A5_5A5A;
    check("hold_ready", 64'(req_ready), 64'd0);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("hold_lat", 64'(cyc), 64'(W + 1));
    check("hold_done", 64'(done), 64'd1);
    check("hold_div", {hi, lo}, model);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'd0;
    model = ref_exec(3'd6, 32'hA5A5_5A5A, 32'd0, model);
    check("hold_mtlo", {hi, lo}, model);

    // Reset in the middle of a divide.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd3;
    src_a     = 32'hFFFF_FF9C;
    src_b     = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_hilo", {hi, lo}, 64'd0);
    check("mrst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model = '0;
    run_op(3'd2, 32'd3, 32'd4, "mrst_mul");
    check("mrst_mul_val", {hi, lo}, 64'd12);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, rnd_opnd(), rnd_opnd(),
             $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
